// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU job sequencer and its delay line.
package tpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } tpu_state_e;

    localparam int PERF_W = 32;

    // Skew in, traverse the array, de-skew out.
    function automatic int tpu_array_lat(input int matrix_size);
        return 2 * matrix_size + 1;
    endfunction

endpackage

// File: rtl/tpu_valid_delay.sv
// Fixed-depth 1-bit valid shift register with async reset and synchronous flush.
module tpu_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic din_i,
    output logic dout_o,
    output logic dout_nxt_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift-and-or form keeps DEPTH=1 legal without a zero-width slice.
    always_comb begin
        sr_d = flush_i ? '0 : ((sr_q << 1) | DEPTH'(din_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sr_q <= '0;
        else         sr_q <= sr_d;
    end

    assign dout_o     = sr_q[DEPTH-1];
    assign dout_nxt_o = sr_d[DEPTH-1];

endmodule

// File: rtl/tpu_job_sequencer.sv
// Job FSM: weight reload, UB streaming and latency-aligned result writes.
// Define TPU_SEQ_PERF_EN to build the perf_cycles job cycle counter.
module tpu_job_sequencer
    import tpu_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WSLOT_W     = 2,
    parameter int MATRIX_SIZE = 64,
    parameter int ARRAY_LAT   = tpu_array_lat(MATRIX_SIZE),
    parameter int WLOAD_CYC   = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  cfg_src_base,
    input  logic [ADDR_W-1:0]  cfg_dst_base,
    input  logic [ADDR_W-1:0]  cfg_num_vec,
    input  logic [WSLOT_W-1:0] cfg_wslot,
    output logic               busy,
    output logic               done,
    output logic               we_rl,
    output logic [WSLOT_W-1:0] w_sel,
    output logic               ub_rd_en,
    output logic [ADDR_W-1:0]  ub_rd_addr,
    output logic               res_wr_en,
    output logic [ADDR_W-1:0]  res_wr_addr,
    output logic [PERF_W-1:0]  perf_cycles
);

    localparam int WL_W = (WLOAD_CYC > 1) ? $clog2(WLOAD_CYC) : 1;
    localparam logic [WL_W-1:0] WL_LAST = WL_W'(WLOAD_CYC - 1);

    tpu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [ADDR_W-1:0]  num_q, num_d;
    logic [WSLOT_W-1:0] w_sel_q, w_sel_d;
    logic [WL_W-1:0]    wl_cnt_q, wl_cnt_d;
    logic [ADDR_W:0]    rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]    wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               busy_q, done_q, we_rl_q, rd_en_q;
    logic               flush;
    logic               wr_en;
    logic               wr_en_nxt;

    assign flush = abort && (state_q != ST_IDLE);

    tpu_valid_delay #(
        .DEPTH (ARRAY_LAT)
    ) u_valid_delay (
        .clk_i      (clk),
        .rst_ni     (rstn),
        .flush_i    (flush),
        .din_i      (rd_en_q),
        .dout_o     (wr_en),
        .dout_nxt_o (wr_en_nxt)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        num_d     = num_q;
        w_sel_d   = w_sel_q;
        wl_cnt_d  = wl_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    src_d    = cfg_src_base;
                    dst_d    = cfg_dst_base;
                    num_d    = cfg_num_vec;
                    w_sel_d  = cfg_wslot;
                    wl_cnt_d = '0;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    state_d  = (cfg_num_vec != '0) ? ST_WLOAD : ST_DONE;
                end
            end
            ST_WLOAD: begin
                if (wl_cnt_q == WL_LAST) state_d = ST_STREAM;
                else                     wl_cnt_d = wl_cnt_q + 1'b1;
            end
            ST_STREAM: begin
                if (rd_cnt_q == {1'b0, num_q}) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wr_cnt_q == {1'b0, num_q}) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (flush) state_d = ST_IDLE;

        // Outputs are registered, so addresses are computed for the cycle being entered.
        if (state_d == ST_STREAM) begin
            rd_addr_d = src_q + rd_cnt_q[ADDR_W-1:0];
            rd_cnt_d  = rd_cnt_q + 1'b1;
        end
        if (wr_en_nxt) begin
            wr_addr_d = dst_q + wr_cnt_q[ADDR_W-1:0];
            wr_cnt_d  = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            num_q     <= '0;
            w_sel_q   <= '0;
            wl_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_rl_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            num_q     <= num_d;
            w_sel_q   <= w_sel_d;
            wl_cnt_q  <= wl_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            we_rl_q   <= (state_d == ST_WLOAD);
            rd_en_q   <= (state_d == ST_STREAM);
        end
    end

`ifdef TPU_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                      perf_q <= '0;
        else if (state_q == ST_IDLE && start && !abort) perf_q <= '0;
        else if (busy_q)                                perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign we_rl       = we_rl_q;
    assign w_sel       = w_sel_q;
    assign ub_rd_en    = rd_en_q;
    assign ub_rd_addr  = rd_addr_q;
    assign res_wr_en   = wr_en;
    assign res_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Scoreboard bench for tpu_job_sequencer (ADDR_W=10, ARRAY_LAT=9, WLOAD_CYC=2).
module tb_tpu_job_sequencer;

    localparam int ADDR_W    = 10;
    localparam int WSLOT_W   = 2;
    localparam int ARRAY_LAT = 9;
    localparam int WLOAD_CYC = 2;
    localparam int NO_CUT    = 32'h3fff_ffff;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [ADDR_W-1:0]  cfg_src_base = '0;
    logic [ADDR_W-1:0]  cfg_dst_base = '0;
    logic [ADDR_W-1:0]  cfg_num_vec = '0;
    logic [WSLOT_W-1:0] cfg_wslot = '0;
    logic               busy, done, we_rl, ub_rd_en, res_wr_en;
    logic [WSLOT_W-1:0] w_sel;
    logic [ADDR_W-1:0]  ub_rd_addr, res_wr_addr;
    logic [31:0]        perf_cycles;

    tpu_job_sequencer #(
        .ADDR_W      (ADDR_W),
        .WSLOT_W     (WSLOT_W),
        .MATRIX_SIZE (4),
        .ARRAY_LAT   (ARRAY_LAT),
        .WLOAD_CYC   (WLOAD_CYC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_num_vec  (cfg_num_vec),
        .cfg_wslot    (cfg_wslot),
        .busy         (busy),
        .done         (done),
        .we_rl        (we_rl),
        .w_sel        (w_sel),
        .ub_rd_en     (ub_rd_en),
        .ub_rd_addr   (ub_rd_addr),
        .res_wr_en    (res_wr_en),
        .res_wr_addr  (res_wr_addr),
        .perf_cycles  (perf_cycles)
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  done_q[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int busy_from = 1, busy_to = 0;
    int wl_from = 1, wl_to = 0;
    logic [WSLOT_W-1:0] exp_wsel = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected activity of one job whose start is sampled on cycle c0; nothing after cut.
    task automatic push_job(input int c0, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                            input int n, input logic [WSLOT_W-1:0] ws, input int cut);
        ev_t e;
        int  dc;
        if (n == 0) begin
            dc      = c0 + 1;
            wl_from = 1;
            wl_to   = 0;
        end else begin
            dc       = c0 + WLOAD_CYC + n + ARRAY_LAT + 1;
            wl_from  = c0 + 1;
            wl_to    = min_i(c0 + WLOAD_CYC, cut);
            exp_wsel = ws;
            for (int unsigned i = 0; i < n; i++) begin
                e.cyc  = c0 + WLOAD_CYC + 1 + int'(i);
                e.addr = src + ADDR_W'(i);
                if (e.cyc <= cut) rd_q.push_back(e);
                e.cyc  = e.cyc + ARRAY_LAT;
                e.addr = dst + ADDR_W'(i);
                if (e.cyc <= cut) wr_q.push_back(e);
            end
        end
        busy_from = c0 + 1;
        busy_to   = min_i(dc, cut);
        if (dc <= cut) done_q.push_back(dc);
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                             input int n, input logic [WSLOT_W-1:0] ws, input int cut_rel);
        start        = 1'b1;
        cfg_src_base = src;
        cfg_dst_base = dst;
        cfg_num_vec  = ADDR_W'(n);
        cfg_wslot    = ws;
        push_job(cyc, src, dst, n, ws, (cut_rel < 0) ? NO_CUT : cyc + cut_rel);
        @(negedge clk);
        start        = 1'b0;
        cfg_src_base = ADDR_W'($urandom());
        cfg_dst_base = ADDR_W'($urandom());
        cfg_num_vec  = ADDR_W'($urandom());
        cfg_wslot    = WSLOT_W'($urandom());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_we_rl"}, 32'(we_rl), 0);
        check({tag, "_w_sel"}, 32'(w_sel), 0);
        check({tag, "_rd_en"}, 32'(ub_rd_en), 0);
        check({tag, "_rd_addr"}, 32'(ub_rd_addr), 0);
        check({tag, "_wr_en"}, 32'(res_wr_en), 0);
        check({tag, "_wr_addr"}, 32'(res_wr_addr), 0);
        check({tag, "_perf"},  perf_cycles, 0);
    endtask

    always @(negedge clk) begin
        bit  eb, ew;
        ev_t e;
        eb = (cyc >= busy_from) && (cyc <= busy_to);
        ew = (cyc >= wl_from) && (cyc <= wl_to);
        check("busy", 32'(busy), 32'(eb));
        check("we_rl", 32'(we_rl), 32'(ew));
        if (ew) check("w_sel", 32'(w_sel), 32'(exp_wsel));
        if (ub_rd_en) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                e = rd_q.pop_front();
                check("rd_cycle", cyc, e.cyc);
                check("rd_addr", 32'(ub_rd_addr), 32'(e.addr));
            end
        end
        if (res_wr_en) begin
            if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                e = wr_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", 32'(res_wr_addr), 32'(e.addr));
            end
        end
        if (done) begin
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else check("done_cycle", cyc, done_q.pop_front());
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Basic job
        start_job(10'h010, 10'h020, 3, 2'd2, -1);
        repeat (20) @(negedge clk);
`ifdef TPU_SEQ_PERF_EN
        check("perf_basic", perf_cycles, 15);
`else
        check("perf_tied", perf_cycles, 0);
`endif

        // Address wrap on both sides
        start_job(10'h3FF, 10'h3FE, 3, 2'd3, -1);
        repeat (20) @(negedge clk);

        // Empty job
        start_job(10'h055, 10'h066, 0, 2'd1, -1);
        repeat (4) @(negedge clk);
`ifdef TPU_SEQ_PERF_EN
        check("perf_empty", perf_cycles, 1);
`else
        check("perf_empty_tied", perf_cycles, 0);
`endif

        // Abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        cfg_num_vec = 10'd4;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(negedge clk);

        // Abort on cycle 4 of an N=5 job, new job on cycle 7
        start_job(10'h100, 10'h200, 5, 2'd1, 4);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        start_job(10'h140, 10'h240, 2, 2'd0, -1);
        repeat (20) @(negedge clk);

        // Second start during a job is ignored; start right after done is accepted
        start_job(10'h0A0, 10'h0B0, 3, 2'd2, -1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        cfg_num_vec = 10'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start_job(10'h300, 10'h310, 1, 2'd1, -1);
        repeat (20) @(negedge clk);

        // Asynchronous reset on cycle 10 of a basic job
        start_job(10'h010, 10'h020, 3, 2'd2, 10);
        repeat (9) @(negedge clk);
        #1 rstn = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        start_job(10'h010, 10'h020, 3, 2'd2, -1);
        repeat (20) @(negedge clk);
`ifdef TPU_SEQ_PERF_EN
        check("perf_after_rst", perf_cycles, 15);
`endif

        check("rd_left", rd_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        check("done_left", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_job_sequencer.md
Name: tpu_job_sequencer

Overview:
- Parametrised job controller for the TPU datapath: Unified Buffer → data-setup skew → systolic array → result de-skew → result SRAM.
- Replaces the free-running result-capture counter and the ad-hoc end detection with one FSM.
- Per job: selects and reloads a weight slot, streams N input vectors from a programmable UB base, and writes N results to a programmable result base at the array's output latency.
- Signals completion with a single-cycle done pulse.

Parameters:
- ADDR_W, 10, UB/result SRAM address width; also the width of the vector count.
- WSLOT_W, 2, weight-SRAM slot select width.
- MATRIX_SIZE, 64, systolic array dimension; informational, used only in the ARRAY_LAT default.
- ARRAY_LAT, 2*MATRIX_SIZE+1, cycles from ub_rd_en to matching valid result at the result SRAM input. Must be ≥1.
- WLOAD_CYC, 1, cycles we_rl is held high for a weight reload. Must be ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  synchronous job cancel.
- cfg_src_base  in  ADDR_W  first UB read address.
- cfg_dst_base  in  ADDR_W  first result write address.
- cfg_num_vec  in  ADDR_W  vector count N; 0 = empty job.
- cfg_wslot  in  WSLOT_W  weight slot.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- we_rl  out  1  weight reload to the array.
- w_sel  out  WSLOT_W  weight SRAM address.
- ub_rd_en  out  1  UB read strobe.
- ub_rd_addr  out  ADDR_W  UB read address.
- res_wr_en  out  1  result SRAM write enable.
- res_wr_addr  out  ADDR_W  result SRAM address.
- perf_cycles  out  32  job cycle count (optional feature).

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset also puts the FSM in IDLE and clears the delay line and all counters.
- Reset asserted mid-job abandons the job immediately; no done pulse is produced.
- States: IDLE, WLOAD, STREAM, DRAIN, DONE.
- **Start acceptance:**
  - start=1 in IDLE with abort=0 is accepted at cycle 0. All cfg_* values are latched at cycle 0 and held for the whole job.
  - start outside IDLE is ignored. Requests are not queued.
- **IDLE:** on accepted start, goes to WLOAD if N≠0, otherwise to DONE.
- **WLOAD:**
  - Cycles 1..WLOAD_CYC: we_rl=1 and w_sel=latched slot.
  - w_sel holds its value until the next job starts.
- **STREAM:**
  - Cycles WLOAD_CYC+1 .. WLOAD_CYC+N: ub_rd_en=1 every cycle.
  - ub_rd_addr = src_base+i for i = 0..N-1, modulo 2^ADDR_W (wraps).
- **Delay line and result writes:**
  - ub_rd_en feeds an ARRAY_LAT-deep delay line whose output drives res_wr_en.
  - A read at cycle t produces a write at cycle t+ARRAY_LAT.
  - res_wr_addr = dst_base+j for the j-th write, modulo 2^ADDR_W.
- **DRAIN:** entered after the last read; left when the write counter reaches N.
- **DONE:**
  - done=1 for exactly one cycle, at cycle WLOAD_CYC+N+ARRAY_LAT+1; for N=0, at cycle 1. Then return to IDLE.
  - busy=1 from cycle 1 through the done cycle inclusive.
- **Abort:**
  - abort=1 in any non-IDLE state: the next state is IDLE and the delay line is flushed, so there are no further writes.
  - busy, we_rl and ub_rd_en are 0 the next cycle; done is not pulsed.
  - abort and start in the same IDLE cycle: abort wins and start is ignored.
- **Counters:** read and write counters are ADDR_W+1 bits wide, so N = 2^ADDR_W−1 completes without overflow.

Optional Feature:
- Macro: TPU_SEQ_PERF_EN.
- Defined:
  - perf_cycles clears to 0 on accepted start and increments every busy cycle.
  - It holds its value after done (equals WLOAD_CYC+N+ARRAY_LAT+1, or 1 for N=0) until the next accepted start.
  - It freezes on abort.
- Undefined: perf_cycles is tied to 0 and no counter is synthesised.

Decomposition:
- Shared package tpu_pkg holds:
  - the state enumeration (IDLE=0, WLOAD=1, STREAM=2, DRAIN=3, DONE=4, 3-bit);
  - default ARRAY_LAT as a function of MATRIX_SIZE;
  - the PERF_W=32 constant.
- One sub-module, tpu_valid_delay: parametrised-depth 1-bit shift register with async reset and synchronous flush, instantiated for the res_wr_en path.

Test Plan (bench: ADDR_W=10, ARRAY_LAT=9, WLOAD_CYC=2):
- Basic job, start at cycle 0 with src=0x010, dst=0x020, N=3, wslot=2:
  - we_rl=1 at cycles 1–2 with w_sel=2;
  - reads at 0x010/0x011/0x012 on cycles 3/4/5;
  - writes at 0x020/0x021/0x022 on cycles 12/13/14;
  - done on cycle 15; perf_cycles=15 when the macro is defined.
- Wrap: src=0x3FF, dst=0x3FE, N=3 → reads 0x3FF, 0x000, 0x001; writes 0x3FE, 0x3FF, 0x000; done on cycle 15.
- Empty job, N=0 → no we_rl, no reads, no writes; done=1 on cycle 1 only; busy high for cycle 1 only.
- Abort on cycle 4, N=5 → from cycle 5 no ub_rd_en and no res_wr_en ever (including reads already in flight); busy=0; done never pulses. A new start on cycle 7 runs normally.
- start pulsed on cycles 0 and 6 with N=3 → second request ignored; exactly one done, on cycle 15. A start on cycle 16 is then accepted.
- rstn low at cycle 10 of the basic job → all outputs 0 asynchronously; no writes after release; the next start behaves as in the basic job.
